// File: rtl/sd_cmd48_generator.sv
// -----------------------------------------------------------------------------
// sd_cmd48_generator
//
// Stimulus generator that serialises a 48-bit SD-style command frame onto
// gen_serial together with a free-running gen_clock. Data changes on the
// falling edge of gen_clock and is stable at its rising edge. The MSB goes out
// first, and a frame starts with the line going 1->0. The six frame bytes are
// loaded through the host command interface, least significant byte first
// (byte k = frame[8k+7:8k]). Optionally bits[7:1] are replaced by the CRC7 of
// bits[47:8], and bit0 by the end bit.
//
// Ports
//   clock                    system clock, all logic on its rising edge
//   reset_n                  asynchronous active-low reset
//   dev_command_started      one-cycle pulse, dev_command valid
//   dev_command_processing   high while the host command is active
//   dev_command[4:0]         command code
//   dev_command_data_signal  one-cycle strobe, dev_data valid
//   dev_data[7:0]            payload byte
//   dev_busy                 high from CMD_SEND acceptance until frame_done
//   crc_auto                 substitute CRC7 + end bit (sampled at acceptance)
//   gen_clock                serial clock, period 2*CLK_DIV clocks
//   gen_serial               serial data, idles high
//   frame_done               one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module sd_cmd48_generator #(
  parameter int          CLK_DIV   = 4,
  parameter int          IDLE_BITS = 8,
  parameter logic [4:0]  CMD_SEND  = 5'h2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       dev_command_started,
  input  logic       dev_command_processing,
  input  logic [4:0] dev_command,
  input  logic       dev_command_data_signal,
  input  logic [7:0] dev_data,
  output logic       dev_busy,
  input  logic       crc_auto,
  output logic       gen_clock,
  output logic       gen_serial,
  output logic       frame_done
);

  localparam int             DW       = $clog2(CLK_DIV);
  localparam int             GW       = $clog2(IDLE_BITS + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0]  GAP_FULL = GW'(IDLE_BITS);
  // x^7 + x^3 + 1 without the implicit x^7 term
  localparam logic [6:0]     CRC_POLY = 7'h09;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT_GAP, ST_SHIFT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_div_cnt;
  logic            r_gen_clock;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_serial;
  logic            r_frame_done;
  logic [47:0]     r_frame;
  logic [2:0]      r_idx;
  logic [5:0]      r_bit_cnt;     // index of the bit currently on the line
  logic [6:0]      r_crc;
  logic            r_crc_auto;
  logic            r_proc_d;

  logic            w_fall;
  logic            w_proc_fell;
  logic            w_cmd_send;
  logic [5:0]      w_next_idx;
  logic [7:0]      w_crc_ext;
  logic            w_next_bit;
  logic [6:0]      w_crc_step;
  logic            w_accept;
  logic            w_store;
  logic            w_start;
  logic            w_shift;
  logic            w_finish;

  // The cycle in which gen_clock is about to toggle 1->0.
  assign w_fall      = (r_div_cnt == DIV_LAST) && r_gen_clock;
  assign w_proc_fell = r_proc_d && !dev_command_processing;
  assign w_cmd_send  = dev_command_started && (dev_command == CMD_SEND);
  assign w_next_idx  = r_bit_cnt - 6'd1;

  // With crc_auto the low byte becomes {CRC[6:0], 1}; indexing this vector with
  // the bit number picks CRC[n-1] for bits 7..1 and the end bit for bit 0.
  assign w_crc_ext   = {r_crc, 1'b1};
  assign w_next_bit  = (r_crc_auto && (w_next_idx < 6'd8)) ? w_crc_ext[w_next_idx[2:0]]
                                                           : r_frame[w_next_idx];
  assign w_crc_step  = {r_crc[5:0], 1'b0} ^ ({7{w_next_bit ^ r_crc[6]}} & CRC_POLY);

  // Next-state logic and one-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_store     = 1'b0;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_send) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The sixth byte completes the load even if the host drops the
        // command in the same cycle; any earlier drop aborts.
        if (dev_command_data_signal && (r_idx == 3'd5)) begin
          w_store     = 1'b1;
          w_state_nxt = ST_WAIT_GAP;
        end else if (w_proc_fell) begin
          w_state_nxt = ST_IDLE;
        end else if (dev_command_data_signal) begin
          w_store     = 1'b1;
        end
      end
      ST_WAIT_GAP: begin
        if (w_fall && (r_gap_cnt == GAP_FULL)) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_fall) begin
          if (r_bit_cnt == 6'd0) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_shift     = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Divider, idle-gap counter and line drivers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt    <= '0;
      r_gen_clock  <= 1'b0;
      r_gap_cnt    <= '0;
      r_serial     <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every always_ff
      // block sees the pre-edge values regardless of evaluation order.
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
      if (r_div_cnt == DIV_LAST) begin
        r_gen_clock <= ~r_gen_clock;
      end

      // High bit-times inside a frame are not idle time, so the gap only
      // accumulates outside SHIFT; a new frame restarts it.
      if (w_start) begin
        r_gap_cnt <= '0;
      end else if (w_fall && r_serial && (r_state != ST_SHIFT) && (r_gap_cnt != GAP_FULL)) begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end

      r_frame_done <= w_finish;
      if (w_start) begin
        r_serial <= 1'b0;                 // start bit, whatever byte 5 held
      end else if (w_shift) begin
        r_serial <= w_next_bit;
      end else if (w_finish) begin
        r_serial <= 1'b1;
      end
    end
  end

  // FSM state, frame load and CRC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_proc_d   <= 1'b0;
      r_crc_auto <= 1'b0;
      r_idx      <= '0;
      r_bit_cnt  <= '0;
      r_crc      <= '0;
      // NOTE: the frame store is a plain 48-bit register, not a RAM, so it is
      // reset along with the rest of the state.
      r_frame    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_proc_d <= dev_command_processing;

      if (w_accept) begin
        r_crc_auto <= crc_auto;
        r_idx      <= '0;
      end

      if (w_store) begin
        r_frame[{r_idx, 3'b000} +: 8] <= dev_data;
        r_idx                         <= r_idx + 3'd1;
      end

      // Bit 47 is always 0 and feeds a zero CRC, so starting from zero
      // already accounts for it.
      if (w_start) begin
        r_bit_cnt <= 6'd47;
        r_crc     <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= w_next_idx;
        if (w_next_idx >= 6'd8) begin
          r_crc <= w_crc_step;
        end
      end
    end
  end

  assign gen_clock  = r_gen_clock;
  assign gen_serial = r_serial;
  assign frame_done = r_frame_done;
  assign dev_busy   = (r_state != ST_IDLE);

endmodule

// File: doc/sd_cmd48_generator.md
Name: sd_cmd48_generator

Overview:
- Stimulus generator that drives 48-bit SD-style command frames onto a serial line plus its clock.
- Mirrors the 48-bit capture path in the logic analyzer:
  - frames start with serial going 1->0;
  - bits change on the falling edge and are stable at the rising edge;
  - MSB goes out first.
- Six frame bytes arrive through the existing host command interface, in the same byte order the analyzer uses for readout (byte k = bits[8k+7:8k]).
- Optionally replaces bits[7:0] with CRC7 and the end bit.

Parameters:
- CLK_DIV, 4, half-period of gen_clock in clock cycles (>=2).
- IDLE_BITS, 8, minimum gen_clock falling edges with gen_serial=1 before any frame start.
- CMD_SEND, 5'h2, command code that loads and sends one frame.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- dev_command_started  in  1  one-cycle pulse; the command code is valid on dev_command.
- dev_command_processing  in  1  high while the host command is active.
- dev_command  in  5  command code.
- dev_command_data_signal  in  1  one-cycle strobe; dev_data is valid.
- dev_data  in  8  payload byte.
- dev_busy  out  1  high from CMD_SEND acceptance until frame_done.
- crc_auto  in  1  when 1, transmitted bits[7:1] = CRC7 and bit0 = 1; sampled at CMD_SEND acceptance.
- gen_clock  out  1  free-running serial clock, period 2*CLK_DIV clocks.
- gen_serial  out  1  serial data; idles at 1.
- frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values: gen_clock=0, gen_serial=1, dev_busy=0, frame_done=0. Also cleared: divider counter, gap counter, bit counter, CRC, frame register; state=IDLE.
- Reset asserted mid-frame aborts it immediately; outputs go to their reset values.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and toggles gen_clock when div_cnt==CLK_DIV-1.
  - "Falling event" = the cycle in which gen_clock is toggled 1->0.
  - gen_serial changes only in that same cycle.
- Gap counter:
  - Counts falling events while gen_serial=1, saturating at IDLE_BITS.
  - Cleared when a frame starts.
- States:
  - IDLE:
    - dev_command_started with dev_command==CMD_SEND: set dev_busy=1, latch crc_auto, byte index=0, go to LOAD.
    - Other codes are ignored.
  - LOAD:
    - Each dev_command_data_signal writes dev_data to frame bits[8*idx+7:8*idx] and increments idx.
    - After the 6th byte, go to WAIT_GAP.
    - If dev_command_processing falls before 6 bytes: go to IDLE, dev_busy=0, nothing transmitted, no frame_done.
  - WAIT_GAP: at the first falling event with gap counter==IDLE_BITS, drive bit47 (forced 0 regardless of the loaded value), set bit counter=46, clear CRC, go to SHIFT.
  - SHIFT:
    - Each falling event drives the next bit, from 46 down to 0.
    - Bits 47..8 feed the CRC7 shift register: polynomial x^7+x^3+1, initial value 0, MSB first.
    - With crc_auto: bits 7..1 come from CRC[6:0], MSB first, and bit0=1. Otherwise the loaded bits are used.
    - At the falling event after bit0: gen_serial=1, frame_done=1 for one cycle, dev_busy=0, go to IDLE.
- Frame length on the line is exactly 48*2*CLK_DIV clocks.
- Data bytes arriving outside LOAD, or beyond the 6th, are ignored.
- CMD_SEND while dev_busy is ignored; the current frame is unaffected.
- dev_command_started and dev_command_data_signal in the same cycle in IDLE: only the command is taken; that byte is not stored.

Test Plan:
- Reset, no commands -> gen_clock toggles every 4 clocks; gen_serial stays 1; dev_busy=0.
- CMD_SEND, crc_auto=1, bytes 00 00 00 00 00 40 -> serial 0x40_00000000_95 MSB first. First 1->0 occurs after >=8 idle falling edges. frame_done pulses 384 clocks after the start bit; dev_busy falls in the same cycle.
- CMD_SEND, crc_auto=1, bytes 00 AA 01 00 00 48 -> serial 0x48_000001AA_87.
- CMD_SEND, crc_auto=0, bytes 12 34 56 78 9A FF -> serial 0x7F_9A785634_12 (bit47 forced 0).
- 3 bytes, then dev_command_processing drops -> no serial activity, dev_busy=0, no frame_done. A following full CMD_SEND transmits normally.
- Second CMD_SEND plus bytes mid-frame -> ignored; the first frame is unchanged. Two back-to-back valid sends -> start bits separated by >=IDLE_BITS high bit-times.
